// File: rtl/pipe_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Groups the pipeline sequencer's hazard, branch and memory handshake signals
// with its per-stage control outputs.
//   slave  : the sequencer (pipe_stall_ctrl) side
//   master : the pipeline / memory side that drives requests and consumes controls
// Optional feature macro: PIPE_PERF_CNT_EN adds stall_cnt, flush_cnt and
// memwait_cnt [CNT_W-1:0].
// -----------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic hazard_stall;
    logic br_taken;
    logic mem_r_en;
    logic mem_w_en;
    logic mem_ready;
    logic mem_req;
    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_ex;
    logic flush_if_id;
    logic freeze_all;
    logic mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;
`endif

    modport slave (
        input  hazard_stall, br_taken, mem_r_en, mem_w_en, mem_ready,
        output mem_req, freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id,
               freeze_all, mem_err
`ifdef PIPE_PERF_CNT_EN
        , output stall_cnt, flush_cnt, memwait_cnt
`endif
    );

    modport master (
        output hazard_stall, br_taken, mem_r_en, mem_w_en, mem_ready,
        input  mem_req, freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id,
               freeze_all, mem_err
`ifdef PIPE_PERF_CNT_EN
        , input stall_cnt, flush_cnt, memwait_cnt
`endif
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central sequencer for the 5-stage core. Merges the hazard-unit stall, the
// EXE-stage branch decision and multi-cycle MEM-stage accesses into per-stage
// freeze / flush / bubble controls, and owns the memory request handshake.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - pipe_stall_ctrl_if.slave: hazard_stall, br_taken, mem_r_en,
//          mem_w_en, mem_ready in; mem_req, freeze_pc, freeze_if_id,
//          bubble_id_ex, flush_if_id, freeze_all, mem_err out.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating performance
// counters (stall_cnt, flush_cnt, memwait_cnt) on the interface.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stall_ctrl_if.slave    bus
);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_err_q, mem_err_d;
    logic             mem_access;

    assign mem_access = bus.mem_r_en | bus.mem_w_en;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (mem_access) begin
                    state_d = MEM_BUSY;
                    timer_d = '0;
                end
            end
            MEM_BUSY: begin
                if (bus.mem_ready) begin
                    state_d = MEM_DONE;
                end else if (timer_q == TMR_LAST) begin
                    state_d   = MEM_DONE;
                    mem_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            // Pipeline advances past the MEM instruction here, so the same
            // access cannot be re-requested on return to RUN.
            MEM_DONE: state_d = RUN;
            default:  state_d = RUN;
        endcase
        // Registered request tracks the state register exactly.
        mem_req_d = (state_d == MEM_BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            timer_q   <= '0;
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_req_q <= mem_req_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Stage controls, priority: memory freeze > branch > hazard stall.
    // While frozen the branch/hazard sources are held, so they are simply
    // re-evaluated once the freeze lifts.
    logic frz_all, frz_pc, frz_ifid, bub_idex, fl_ifid;
    logic prio_flush, prio_stall;

    always_comb begin
        frz_all    = (state_q == MEM_BUSY) | ((state_q == RUN) & mem_access);
        prio_flush = 1'b0;
        prio_stall = 1'b0;
        frz_pc     = 1'b0;
        frz_ifid   = 1'b0;
        bub_idex   = 1'b0;
        fl_ifid    = 1'b0;
        if (!frz_all) begin
            if (bus.br_taken) begin
                // ID holds a wrong-path instruction, so the stall is moot.
                prio_flush = 1'b1;
                fl_ifid    = 1'b1;
                bub_idex   = 1'b1;
            end else if (bus.hazard_stall) begin
                prio_stall = 1'b1;
                frz_pc     = 1'b1;
                frz_ifid   = 1'b1;
                bub_idex   = 1'b1;
            end
        end
    end

    assign bus.freeze_all   = frz_all;
    assign bus.freeze_pc    = frz_pc;
    assign bus.freeze_if_id = frz_ifid;
    assign bus.bubble_id_ex = bub_idex;
    assign bus.flush_if_id  = fl_ifid;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_err      = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        stall_cnt_d   = sat_inc(stall_cnt_q, prio_stall);
        flush_cnt_d   = sat_inc(flush_cnt_q, prio_flush);
        memwait_cnt_d = sat_inc(memwait_cnt_q, frz_all);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {freeze_all, freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id}
    function automatic logic [31:0] ctl();
        return {27'd0, bus.freeze_all, bus.freeze_pc, bus.freeze_if_id,
                bus.bubble_id_ex, bus.flush_if_id};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hz, input logic br, input logic rd,
                         input logic wr, input logic rdy);
        bus.hazard_stall = hz;
        bus.br_taken     = br;
        bus.mem_r_en     = rd;
        bus.mem_w_en     = wr;
        bus.mem_ready    = rdy;
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        #12;
        // Reset state
        chk("rst_req", bus.mem_req, 0);
        chk("rst_err", bus.mem_err, 0);
        chk("rst_ctl", ctl(), 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Hazard stall for two cycles
        drive(1, 0, 0, 0, 0);
        chk("hz_c1", ctl(), 5'b01110);
        tick();
        chk("hz_c2", ctl(), 5'b01110);
        drive(0, 0, 0, 0, 0);
        chk("idle", ctl(), 5'b00000);

        // Branch overrides hazard
        drive(1, 1, 0, 0, 0);
        chk("br_hz", ctl(), 5'b00011);
        drive(0, 1, 0, 0, 0);
        chk("br_only", ctl(), 5'b00011);

        // mem_ready in RUN is ignored
        drive(0, 0, 0, 0, 1);
        tick();
        chk("rdy_run_req", bus.mem_req, 0);
        chk("rdy_run_ctl", ctl(), 5'b00000);

        // Read: request at T, ready at T+3
        drive(1, 1, 1, 0, 0);                 // T: freeze_all masks branch/hazard
        chk("rd_T_ctl", ctl(), 5'b10000);
        chk("rd_T_req", bus.mem_req, 0);
        tick();                               // T+1
        chk("rd_T1_req", bus.mem_req, 1);
        chk("rd_T1_ctl", ctl(), 5'b10000);
        tick();                               // T+2
        chk("rd_T2_req", bus.mem_req, 1);
        drive(1, 1, 1, 0, 1);                 // T+3 ready
        chk("rd_T3_req", bus.mem_req, 1);
        chk("rd_T3_ctl", ctl(), 5'b10000);
        tick();                               // T+4 MEM_DONE
        drive(0, 1, 1, 0, 1);                 // mem_r_en/ready ignored in DONE
        chk("rd_T4_req", bus.mem_req, 0);
        chk("rd_T4_ctl", ctl(), 5'b00011);
        drive(0, 0, 0, 0, 0);
        tick();                               // T+5 RUN
        chk("rd_T5_req", bus.mem_req, 0);
        chk("rd_T5_ctl", ctl(), 5'b00000);
        chk("rd_T5_err", bus.mem_err, 0);

        // Write with no ready: timeout after TIMEOUT busy cycles
        drive(0, 0, 0, 1, 0);
        chk("to_T_ctl", ctl(), 5'b10000);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            chk($sformatf("to_busy%0d_req", i), bus.mem_req, 1);
            chk($sformatf("to_busy%0d_err", i), bus.mem_err, 0);
        end
        tick();                               // MEM_DONE
        chk("to_done_req", bus.mem_req, 0);
        chk("to_done_err", bus.mem_err, 1);
        chk("to_done_ctl", ctl(), 5'b00000);  // mem_w_en still high, but DONE
        tick();                               // RUN again, write retriggers
        chk("b2b_ctl", ctl(), 5'b10000);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("err_sticky", bus.mem_err, 1);

        // Reset in the middle of MEM_BUSY
        drive(0, 0, 1, 0, 0);
        tick();
        chk("mid_req_pre", bus.mem_req, 1);
        rst = 1'b0;
        #1;
        chk("mid_req_drop", bus.mem_req, 0);
        chk("mid_err_clr", bus.mem_err, 0);
        chk("mid_ctl_run", ctl(), 5'b10000);  // back in RUN with mem_r_en high
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_req", bus.mem_req, 0);
        chk("post_rst_ctl", ctl(), 5'b00000);
        chk("post_rst_err", bus.mem_err, 0);

`ifdef PIPE_PERF_CNT_EN
        rst = 1'b0;
        #1;
        chk("cnt_rst", bus.stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        drive(0, 0, 0, 0, 0);
        chk("cnt_sat", bus.stall_cnt, 3);
        chk("cnt_flush", bus.flush_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
